// File: rtl/exec_datapath.sv
// Execution datapath: responder side of the controller enable/done handshake.
// Runs single-cycle ALU ops and an 8-step shift-add multiply from latched operands.
module exec_datapath #(
    parameter int WIDTH = 16,
    parameter int OPW   = 4,
    parameter int DW    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [OPW-1:0]   opcode,
    input  logic [DW-1:0]    a,
    input  logic [DW-1:0]    b,
    output logic             done,
    output logic             busy,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             error
);

    localparam int CW = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(DW - 1);
    localparam logic [OPW-1:0] OP_ADD   = OPW'(4'b0000);
    localparam logic [OPW-1:0] OP_SUB   = OPW'(4'b0001);
    localparam logic [OPW-1:0] OP_MUL   = OPW'(4'b0010);
    localparam logic [OPW-1:0] OP_AND   = OPW'(4'b0011);
    localparam logic [OPW-1:0] OP_CLR   = OPW'(4'b1011);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_EXEC     = 3'd1,
        ST_MUL      = 3'd2,
        ST_DONE     = 3'd3,
        ST_WAIT_LOW = 3'd4
    } state_t;

    state_t              state_r;
    logic [OPW-1:0]      op_r;
    logic [DW-1:0]       a_r;
    logic [DW-1:0]       b_r;
    logic [CW-1:0]       cnt_r;
    logic [2*DW-1:0]     acc_r;
    logic [2*DW-1:0]     mcand_r;
    logic [DW-1:0]       mplier_r;
    logic                done_r;
    logic                busy_r;
    logic [WIDTH-1:0]    result_r;
    logic                zero_r;
    logic                error_r;

    logic [2*DW-1:0]     add_term_s;
    logic [2*DW-1:0]     acc_next_s;
    logic [WIDTH-1:0]    exec_result_s;
    logic                exec_valid_s;

    // Next multiply accumulator and single-cycle ALU result from latched operands.
    always_comb begin
        add_term_s    = {(2*DW){1'b0}};
        exec_valid_s  = 1'b1;
        exec_result_s = result_r;
        if (mplier_r[0]) begin
            add_term_s = mcand_r;
        end else begin
            add_term_s = {(2*DW){1'b0}};
        end
        acc_next_s = acc_r + add_term_s;
        case (op_r)
            OP_ADD:  exec_result_s = WIDTH'(a_r) + WIDTH'(b_r);
            OP_SUB:  exec_result_s = WIDTH'(a_r) - WIDTH'(b_r);
            OP_AND:  exec_result_s = WIDTH'(a_r & b_r);
            OP_CLR:  exec_result_s = {WIDTH{1'b0}};
            default: begin
                // Unsupported opcode leaves the previous result in place.
                exec_valid_s  = 1'b0;
                exec_result_s = result_r;
            end
        endcase
    end

    // Handshake FSM, operand latch, shift-add multiplier and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            op_r     <= {OPW{1'b0}};
            a_r      <= {DW{1'b0}};
            b_r      <= {DW{1'b0}};
            cnt_r    <= {CW{1'b0}};
            acc_r    <= {(2*DW){1'b0}};
            mcand_r  <= {(2*DW){1'b0}};
            mplier_r <= {DW{1'b0}};
            done_r   <= 1'b0;
            busy_r   <= 1'b0;
            result_r <= {WIDTH{1'b0}};
            zero_r   <= 1'b1;
            error_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (enable) begin
                        op_r     <= opcode;
                        a_r      <= a;
                        b_r      <= b;
                        cnt_r    <= {CW{1'b0}};
                        acc_r    <= {(2*DW){1'b0}};
                        mcand_r  <= {{DW{1'b0}}, a};
                        mplier_r <= b;
                        busy_r   <= 1'b1;
                        state_r  <= (opcode == OP_MUL) ? ST_MUL : ST_EXEC;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                ST_EXEC: begin
                    result_r <= exec_result_s;
                    zero_r   <= (exec_result_s == {WIDTH{1'b0}});
                    error_r  <= ~exec_valid_s;
                    done_r   <= 1'b1;
                    state_r  <= ST_DONE;
                end
                ST_MUL: begin
                    acc_r    <= acc_next_s;
                    mcand_r  <= {mcand_r[2*DW-2:0], 1'b0};
                    mplier_r <= {1'b0, mplier_r[DW-1:1]};
                    cnt_r    <= cnt_r + CW'(1);
                    if (cnt_r == CNT_LAST) begin
                        result_r <= WIDTH'(acc_next_s);
                        zero_r   <= (acc_next_s == {(2*DW){1'b0}});
                        error_r  <= 1'b0;
                        done_r   <= 1'b1;
                        state_r  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_WAIT_LOW;
                end
                ST_WAIT_LOW: begin
                    // Hold here until the controller releases enable, so a held
                    // request cannot retrigger the same instruction.
                    if (!enable) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign done   = done_r;
    assign busy   = busy_r;
    assign result = result_r;
    assign zero   = zero_r;
    assign error  = error_r;

endmodule
